tx_framer_8b10b: RTL

- Link-layer transmit scheduler that drives the 8b/10b encoder input (k_en, data_in) with exactly one symbol every clock.
- Round-robin arbitrates two byte-stream requesters.
- Wraps each granted frame in SOF/EOF control symbols and fills gaps with K28.5 commas.
- Sends an alignment burst of commas after reset, and enforces a minimum comma gap between frames for receiver word alignment.

---
 rtl/tx_framer_8b10b_pkg.sv | 30 +++
 rtl/tx_framer_8b10b_arb.sv | 32 +++
 rtl/tx_framer_8b10b.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tx_framer_8b10b_pkg.sv
// Shared 8b/10b link-layer definitions: K-symbol bytes, framer states and a
// small symbol record used on the encoder interface.
package tx_framer_8b10b_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K28_0 = 8'h1C;

  typedef enum logic [2:0] {
    ST_ALIGN,
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF
  } state_t;

  typedef struct packed {
    logic       k;
    logic [7:0] data;
  } symbol_t;

  function automatic symbol_t make_sym(input logic k, input logic [7:0] data);
    symbol_t s;
    s.k    = k;
    s.data = data;
    return s;
  endfunction

endpackage

// File: rtl/tx_framer_8b10b_arb.sv
// Two-way round-robin arbiter. The pointer names the preferred requester and
// moves to the other one whenever a grant is taken with the update strobe.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] request,
  input  logic       update,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (ptr == 1'b0) begin
      if (request[0])      grant = 2'b01;
      else if (request[1]) grant = 2'b10;
    end else begin
      if (request[1])      grant = 2'b10;
      else if (request[0]) grant = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/tx_framer_8b10b.sv
// Transmit framer feeding an 8b/10b encoder: alignment burst, round-robin
// frame scheduling, SOF/EOF wrapping, underrun fill and inter-frame commas.
module tx_framer_8b10b
  import tx_framer_8b10b_pkg::*;
#(
  parameter int ALIGN_CNT = 16,
  parameter int IDLE_MIN  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       enc_k_en,
  output logic [7:0] enc_data,
  output logic       link_up,
  output logic       busy,
  output logic [1:0] grant
);

  localparam logic [9:0] ALIGN_LAST = 10'(ALIGN_CNT - 1);
  localparam logic [7:0] IDLE_SAT   = 8'(IDLE_MIN);
  localparam logic [7:0] IDLE_GO    = 8'(IDLE_MIN - 1);

  state_t     state;
  state_t     state_next;
  logic [9:0] align_cnt;
  logic [7:0] idle_cnt;
  logic [1:0] owner;
  logic [1:0] arb_grant;
  logic       start;
  logic       xfer;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       align_done;
  symbol_t    sym_next;
  logic       busy_next;
  logic [1:0] grant_next;
  logic       link_up_next;

  assign s0_ready = (state == ST_DATA) && owner[0];
  assign s1_ready = (state == ST_DATA) && owner[1];

  assign xfer     = (state == ST_DATA) &&
                    ((owner[0] && s0_valid) || (owner[1] && s1_valid));
  assign sel_last = owner[1] ? s1_last : s0_last;
  assign sel_data = owner[1] ? s1_data : s0_data;

  assign align_done = (state == ST_ALIGN) && (align_cnt == ALIGN_LAST);

  // The idle count includes the comma leaving on this cycle, so arbitration
  // fires on the IDLE_MIN-th comma and SOF follows exactly IDLE_MIN commas.
  assign start = (state == ST_IDLE) && (idle_cnt >= IDLE_GO) && tx_en &&
                 (s0_valid || s1_valid);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .request ({s1_valid, s0_valid}),
    .update  (start),
    .grant   (arb_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ALIGN;
      align_cnt <= '0;
      idle_cnt  <= '0;
      owner     <= '0;
    end else begin
      state <= state_next;
      if (state == ST_ALIGN) begin
        if (align_done) idle_cnt  <= IDLE_SAT;
        else            align_cnt <= align_cnt + 10'd1;
      end
      if ((state == ST_IDLE) && (idle_cnt < IDLE_SAT)) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
      if (start) begin
        owner <= arb_grant;
      end
      if (state == ST_EOF) begin
        owner    <= '0;
        idle_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ALIGN: if (align_done) state_next = ST_IDLE;
      ST_IDLE:  if (start) state_next = ST_SOF;
      ST_SOF:   state_next = ST_DATA;
      ST_DATA:  if (xfer && sel_last) state_next = ST_EOF;
      ST_EOF:   state_next = ST_IDLE;
      default:  state_next = ST_ALIGN;
    endcase
  end

  // Each cycle's state or transfer becomes the symbol on the wire next cycle.
  always_comb begin
    sym_next     = make_sym(1'b1, K28_5);
    busy_next    = 1'b0;
    grant_next   = 2'b00;
    link_up_next = link_up | align_done;
    case (state)
      ST_SOF:  sym_next = make_sym(1'b1, K27_7);
      ST_DATA: sym_next = xfer ? make_sym(1'b0, sel_data) : make_sym(1'b1, K28_0);
      ST_EOF:  sym_next = make_sym(1'b1, K29_7);
      default: sym_next = make_sym(1'b1, K28_5);
    endcase
    if ((state == ST_SOF) || (state == ST_DATA) || (state == ST_EOF)) begin
      busy_next  = 1'b1;
      grant_next = owner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_k_en <= 1'b1;
      enc_data <= K28_5;
      link_up  <= 1'b0;
      busy     <= 1'b0;
      grant    <= 2'b00;
    end else begin
      enc_k_en <= sym_next.k;
      enc_data <= sym_next.data;
      link_up  <= link_up_next;
      busy     <= busy_next;
      grant    <= grant_next;
    end
  end

endmodule
